// File: rtl/data_memory_ctrl.sv
// MEM-stage data memory controller: word-organised RAM with byte-lane stores and a
// fixed-latency stall FSM. Returns the raw registered word plus its byte offset.
module data_memory_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  StoreSel,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic [1:0]  ByteOffset,
   output logic        Stall,
   output logic        AccessDone,
   output logic        MisalignedExc
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   // Handshake: a request (MemRead|MemWrite) is accepted in IDLE; the pipeline must hold
   // its inputs while Stall=1, and AccessDone pulses for one cycle when ReadData is valid.
   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [31:0]   read_data_q, read_data_d;
   logic [1:0]    byte_offset_q, byte_offset_d;
   logic          access_done_q, access_done_d;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] index;
   logic          req, misaligned, commit, rd_commit, wr_commit;
   logic [3:0]    lane_en;
   logic [31:0]   lane_data;
   logic          unused_addr;

   assign index       = Address[AW+1:2];
   assign unused_addr = ^Address[31:AW+2];
   assign req         = MemRead | MemWrite;

   always_comb begin
      misaligned = 1'b0;
      lane_en    = 4'b1111;
      lane_data  = WriteData;
      case (StoreSel)
         2'b01: begin
            misaligned = MemWrite & Address[0];
            lane_en    = Address[1] ? 4'b1100 : 4'b0011;
            lane_data  = {2{WriteData[15:0]}};
         end
         2'b10: begin
            lane_en    = 4'b0001 << Address[1:0];
            lane_data  = {4{WriteData[7:0]}};
         end
         default: misaligned = MemWrite & (Address[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req && !misaligned) begin
               cnt_d = CNT_INIT;
               if (WAIT_STATES == 1) begin
                  commit  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd1) begin
               commit  = 1'b1;
               cnt_d   = 4'd0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // A simultaneous read+write performs only the write; ReadData keeps its old value.
      rd_commit     = commit & MemRead & ~MemWrite;
      wr_commit     = commit & MemWrite;
      read_data_d   = rd_commit ? mem[index] : read_data_q;
      byte_offset_d = rd_commit ? Address[1:0] : byte_offset_q;
      access_done_d = commit;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         read_data_q   <= 32'd0;
         byte_offset_q <= 2'd0;
         access_done_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         read_data_q   <= read_data_d;
         byte_offset_q <= byte_offset_d;
         access_done_q <= access_done_d;
      end
   end

   // RAM contents survive reset; only the commit itself is blocked by it.
   always_ff @(posedge Clk) begin
      if (wr_commit && !Reset) begin
         for (int k = 0; k < 4; k++) begin
            if (lane_en[k]) mem[index][8*k +: 8] <= lane_data[8*k +: 8];
         end
      end
   end

   assign ReadData      = read_data_q;
   assign ByteOffset    = byte_offset_q;
   assign AccessDone    = access_done_q;
   assign Stall         = ~Reset & ((state_q == ST_WAIT) |
                                    ((state_q == ST_IDLE) & req & ~misaligned));
   assign MisalignedExc = ~Reset & (state_q == ST_IDLE) & misaligned;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: reference RAM model with an expected-read queue, directed
// lane/alias/reset cases and a short random mix.
module tb_data_memory_ctrl;

   localparam int DEPTH = 1024;
   localparam int WS    = 2;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        MemRead, MemWrite;
   logic [1:0]  StoreSel;
   logic [31:0] Address, WriteData;
   logic [31:0] ReadData;
   logic [1:0]  ByteOffset;
   logic        Stall, AccessDone, MisalignedExc;

   data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
      .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .StoreSel(StoreSel), .Address(Address), .WriteData(WriteData),
      .ReadData(ReadData), .ByteOffset(ByteOffset), .Stall(Stall),
      .AccessDone(AccessDone), .MisalignedExc(MisalignedExc)
   );

   always #5 Clk = ~Clk;

   // Scoreboard state
   logic [31:0] model [DEPTH];
   logic [33:0] exp_q[$];
   logic [33:0] last_rd;
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_store(input logic [1:0] sel, input logic [31:0] addr,
                                       input logic [31:0] wd);
      int idx;
      idx = int'(addr[11:2]);
      case (sel)
         2'b01: if (addr[1]) model[idx][31:16] = wd[15:0];
                else         model[idx][15:0]  = wd[15:0];
         2'b10: model[idx][8*addr[1:0] +: 8] = wd[7:0];
         default: model[idx] = wd;
      endcase
   endfunction

   task automatic idle_inputs();
      MemRead = 1'b0; MemWrite = 1'b0; StoreSel = 2'b00;
      Address = 32'd0; WriteData = 32'd0;
   endtask

   // Called just after a rising edge; returns just after a rising edge with inputs idle.
   task automatic access(input logic rd, input logic wr, input logic [1:0] sel,
                         input logic [31:0] addr, input logic [31:0] wd);
      int  stall_cnt;
      bit  done;
      bit  is_read;
      logic [33:0] e;
      is_read = rd & ~wr;
      if (is_read) exp_q.push_back({addr[1:0], model[int'(addr[11:2])]});
      if (wr) model_store(sel, addr, wd);
      MemRead = rd; MemWrite = wr; StoreSel = sel; Address = addr; WriteData = wd;
      stall_cnt = 0;
      done = 1'b0;
      for (int cyc = 0; cyc < 20 && !done; cyc++) begin
         @(negedge Clk);
         check_eq("misaligned_exc_quiet", MisalignedExc, 1'b0);
         if (AccessDone) begin
            done = 1'b1;
            check_eq("stall_in_done", Stall, 1'b0);
         end else begin
            if (Stall) stall_cnt++;
            @(posedge Clk); #1;
         end
      end
      if (!done) check_eq("access_timeout", 1'b0, 1'b1);
      check_eq("stall_cycles", stall_cnt, WS);
      if (is_read && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("read_data", ReadData, e[31:0]);
         check_eq("byte_offset", ByteOffset, e[33:32]);
         last_rd = e;
      end else begin
         check_eq("read_data_hold", {ByteOffset, ReadData}, last_rd);
      end
      @(posedge Clk); #1;
      idle_inputs();
      @(negedge Clk);
      check_eq("done_single_pulse", AccessDone, 1'b0);
      check_eq("stall_after_done", Stall, 1'b0);
      @(posedge Clk); #1;
   endtask

   task automatic misaligned_store(input logic [1:0] sel, input logic [31:0] addr,
                                   input logic [31:0] wd);
      MemRead = 1'b0; MemWrite = 1'b1; StoreSel = sel; Address = addr; WriteData = wd;
      @(negedge Clk);
      check_eq("misaligned_exc", MisalignedExc, 1'b1);
      check_eq("misaligned_stall", Stall, 1'b0);
      @(posedge Clk); #1;
      idle_inputs();
      @(negedge Clk);
      check_eq("misaligned_no_done", AccessDone, 1'b0);
      @(posedge Clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, d;
      int          kind;
      Reset = 1'b1;
      idle_inputs();
      last_rd = 34'd0;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(negedge Clk);
      check_eq("rst_read_data", ReadData, 32'd0);
      check_eq("rst_byte_offset", ByteOffset, 2'd0);
      check_eq("rst_stall", Stall, 1'b0);
      check_eq("rst_access_done", AccessDone, 1'b0);
      check_eq("rst_misaligned", MisalignedExc, 1'b0);
      @(posedge Clk); #1;

      // Preload a window so every later read has a known value
      for (int w = 0; w < 32; w++) access(1'b0, 1'b1, 2'b00, 32'(w * 4), $urandom);

      access(1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF);
      access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
      check_eq("lw_10_const", ReadData, 32'hDEADBEEF);

      access(1'b0, 1'b1, 2'b00, 32'h20, 32'h11223344);
      access(1'b0, 1'b1, 2'b10, 32'h22, 32'h000000AA);
      access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
      check_eq("sb_lane2_const", ReadData, 32'h11AA3344);
      access(1'b0, 1'b1, 2'b01, 32'h20, 32'h0000BEEF);
      access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
      check_eq("sh_low_const", ReadData, 32'h11AABEEF);
      access(1'b0, 1'b1, 2'b01, 32'h22, 32'hFFFF1234);
      access(1'b0, 1'b1, 2'b10, 32'h20, 32'h00000077);
      access(1'b1, 1'b0, 2'b00, 32'h23, 32'h0);
      check_eq("sh_high_sb0_const", ReadData, 32'h1234BE77);

      misaligned_store(2'b00, 32'h21, 32'hCAFECAFE);
      misaligned_store(2'b01, 32'h23, 32'hCAFECAFE);
      misaligned_store(2'b11, 32'h22, 32'hCAFECAFE);
      access(1'b1, 1'b0, 2'b00, 32'h20, 32'h0);
      check_eq("misaligned_unchanged", ReadData, 32'h1234BE77);

      // Reset lands on the commit edge of a store: the store must be dropped
      access(1'b1, 1'b0, 2'b00, 32'h34, 32'h0);
      MemRead = 1'b0; MemWrite = 1'b1; StoreSel = 2'b00;
      Address = 32'h30; WriteData = 32'h12345678;
      @(negedge Clk);
      check_eq("rst_mid_stall_idle", Stall, 1'b1);
      @(posedge Clk); #1;
      @(negedge Clk);
      check_eq("rst_mid_stall_wait", Stall, 1'b1);
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      idle_inputs();
      @(negedge Clk);
      check_eq("rst_mid_stall_after", Stall, 1'b0);
      check_eq("rst_mid_done_after", AccessDone, 1'b0);
      check_eq("rst_mid_read_data", ReadData, 32'd0);
      last_rd = 34'd0;
      @(posedge Clk); #1;
      access(1'b1, 1'b0, 2'b00, 32'h30, 32'h0);

      access(1'b0, 1'b1, 2'b00, 32'h1010, 32'hA5A55A5A);
      access(1'b1, 1'b0, 2'b00, 32'h10, 32'h0);
      check_eq("alias_const", ReadData, 32'hA5A55A5A);

      access(1'b1, 1'b1, 2'b00, 32'h40, 32'h00000055);
      access(1'b1, 1'b0, 2'b00, 32'h40, 32'h0);
      check_eq("rw_both_const", ReadData, 32'h00000055);

      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 3);
         a    = 32'($urandom_range(0, 31) * 4);
         d    = $urandom;
         case (kind)
            0: access(1'b1, 1'b0, 2'b00, a + 32'($urandom_range(0, 3)), 32'h0);
            1: access(1'b0, 1'b1, 2'($urandom_range(0, 1) * 3), a, d);
            2: access(1'b0, 1'b1, 2'b01, a + 32'($urandom_range(0, 1) * 2), d);
            default: access(1'b0, 1'b1, 2'b10, a + 32'($urandom_range(0, 3)), d);
         endcase
      end
      for (int w = 0; w < 32; w++) access(1'b1, 1'b0, 2'b00, 32'(w * 4), 32'h0);

      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
